shk_reg_slave: RTL and testbench

//   Synthesizable shake-bus slave: register-bank responder for shake masters (e.g. init sequencers).

---
 rtl/shk_reg_slave.sv | 143 ++++++++++++++
 tb/tb_shk_reg_slave.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shk_reg_slave.sv
// Shake-bus register slave.
// Captures a request when idle, writes or reads one register of a flat bank,
// and answers with a single-cycle ready pulse NB_RESP_DELAY cycles later.
// Requests arriving while a response is pending are dropped and flagged.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no request pending; a valid request is captured here
//   WAIT    | request captured; counting down to the response cycle
//   RESP    | ready pulse is high for this one cycle
module shk_reg_slave #(
    parameter int WD_SHK_DATA   = 16,
    parameter int WD_SHK_ADDR   = 16,
    parameter int NB_REG_NUM    = 8,
    parameter int NB_ADDR_BASE  = 0,
    parameter int NB_RESP_DELAY = 2,
    parameter int NB_REG_INIT   = 0,
    parameter int WD_ERR_INFO   = 4
) (
    input  logic                              i_sys_clk,
    input  logic                              i_sys_reset,
    input  logic                              s_shk_reg_valid,
    input  logic                              s_shk_reg_msync,
    input  logic [WD_SHK_DATA-1:0]            s_shk_reg_mdata,
    input  logic [WD_SHK_ADDR-1:0]            s_shk_reg_maddr,
    output logic                              s_shk_reg_ready,
    output logic                              s_shk_reg_ssync,
    output logic [WD_SHK_DATA-1:0]            s_shk_reg_sdata,
    output logic [WD_SHK_ADDR-1:0]            s_shk_reg_saddr,
    output logic [NB_REG_NUM*WD_SHK_DATA-1:0] o_reg_flat,
    output logic [WD_ERR_INFO-1:0]            m_err_reg_info1
);

    localparam int IDX_W = (NB_REG_NUM > 1) ? $clog2(NB_REG_NUM) : 1;
    // The counter holds NB_RESP_DELAY-2 at most, so clog2(NB_RESP_DELAY) bits suffice.
    localparam int CNT_W = (NB_RESP_DELAY > 2) ? $clog2(NB_RESP_DELAY) : 1;

    localparam logic [CNT_W-1:0]       CNT_LOAD  = (NB_RESP_DELAY >= 2) ? CNT_W'(NB_RESP_DELAY - 2) : '0;
    localparam logic [WD_SHK_ADDR-1:0] ADDR_BASE = WD_SHK_ADDR'(NB_ADDR_BASE);
    localparam logic [WD_SHK_ADDR-1:0] REG_NUM_A = WD_SHK_ADDR'(NB_REG_NUM);
    localparam logic [WD_SHK_DATA-1:0] REG_INIT  = WD_SHK_DATA'(NB_REG_INIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [WD_SHK_DATA-1:0] regs [NB_REG_NUM];
    logic [1:0]             err_flags;

    logic [WD_SHK_ADDR-1:0] idx;
    logic [IDX_W-1:0]       sel;
    logic                   in_range;

    // Address decode: the subtraction wraps, so the lower bound is checked separately.
    always_comb begin
        idx      = s_shk_reg_maddr - ADDR_BASE;
        sel      = idx[IDX_W-1:0];
        in_range = (s_shk_reg_maddr >= ADDR_BASE) && (idx < REG_NUM_A);
    end

    // Request FSM, register bank, response registers and sticky error flags.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            s_shk_reg_ready <= 1'b0;
            s_shk_reg_ssync <= 1'b0;
            s_shk_reg_sdata <= '0;
            s_shk_reg_saddr <= '0;
            err_flags       <= 2'b00;
            for (int i = 0; i < NB_REG_NUM; i++) begin
                regs[i] <= REG_INIT;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_shk_reg_valid) begin
                        s_shk_reg_ssync <= s_shk_reg_msync;
                        s_shk_reg_saddr <= s_shk_reg_maddr;
                        if (in_range) begin
                            if (s_shk_reg_msync) begin
                                s_shk_reg_sdata <= regs[sel];
                            end else begin
                                regs[sel]       <= s_shk_reg_mdata;
                                s_shk_reg_sdata <= s_shk_reg_mdata;
                            end
                        end else begin
                            s_shk_reg_sdata <= '0;
                            err_flags[0]    <= 1'b1;
                        end
                        if (NB_RESP_DELAY == 1) begin
                            state           <= ST_RESP;
                            s_shk_reg_ready <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (s_shk_reg_valid) begin
                        err_flags[1] <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state           <= ST_RESP;
                        s_shk_reg_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (s_shk_reg_valid) begin
                        err_flags[1] <= 1'b1;
                    end
                    s_shk_reg_ready <= 1'b0;
                    state           <= ST_IDLE;
                end
                default: begin
                    s_shk_reg_ready <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

    // Only the two low error bits carry information; the rest read as zero.
    always_comb begin
        m_err_reg_info1      = '0;
        m_err_reg_info1[1:0] = err_flags;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB_REG_NUM; gi++) begin : g_flat
            assign o_reg_flat[gi*WD_SHK_DATA +: WD_SHK_DATA] = regs[gi];
        end
    endgenerate

endmodule

// File: tb/tb_shk_reg_slave.sv
// Testbench for shk_reg_slave: directed vector table, randomized requests
// against an array-based model, reset-abort sequence, and a second instance
// with single-cycle response delay and a nonzero address base.
module tb_shk_reg_slave;

    logic         clk = 1'b0;
    logic         rst;

    logic         valid, msync;
    logic [15:0]  mdata, maddr;
    logic         ready, ssync;
    logic [15:0]  sdata, saddr;
    logic [127:0] flat;
    logic [3:0]   err;

    logic         valid6, msync6;
    logic [15:0]  mdata6, maddr6;
    logic         ready6, ssync6;
    logic [15:0]  sdata6, saddr6;
    logic [127:0] flat6;
    logic [3:0]   err6;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_regs [8];
    logic [1:0]  m_err;

    always #5 clk = ~clk;

    shk_reg_slave dut (
        .i_sys_clk       (clk),
        .i_sys_reset     (rst),
        .s_shk_reg_valid (valid),
        .s_shk_reg_msync (msync),
        .s_shk_reg_mdata (mdata),
        .s_shk_reg_maddr (maddr),
        .s_shk_reg_ready (ready),
        .s_shk_reg_ssync (ssync),
        .s_shk_reg_sdata (sdata),
        .s_shk_reg_saddr (saddr),
        .o_reg_flat      (flat),
        .m_err_reg_info1 (err)
    );

    shk_reg_slave #(
        .NB_RESP_DELAY (1),
        .NB_ADDR_BASE  (16'h10)
    ) dut6 (
        .i_sys_clk       (clk),
        .i_sys_reset     (rst),
        .s_shk_reg_valid (valid6),
        .s_shk_reg_msync (msync6),
        .s_shk_reg_mdata (mdata6),
        .s_shk_reg_maddr (maddr6),
        .s_shk_reg_ready (ready6),
        .s_shk_reg_ssync (ssync6),
        .s_shk_reg_sdata (sdata6),
        .s_shk_reg_saddr (saddr6),
        .o_reg_flat      (flat6),
        .m_err_reg_info1 (err6)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int i = 0; i < 8; i++) f[i*16 +: 16] = m_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_err = 2'b00;
    endtask

    // Model of one request on the default instance (base 0, 8 registers).
    task automatic model_req(input logic sync, input logic [15:0] addr, input logic [15:0] data,
                             input logic poke, output logic [15:0] exp_sdata);
        if (addr >= 16'd8) begin
            m_err[0]  = 1'b1;
            exp_sdata = 16'h0;
        end else if (sync) begin
            exp_sdata = m_regs[addr[2:0]];
        end else begin
            m_regs[addr[2:0]] = data;
            exp_sdata         = data;
        end
        if (poke) m_err[1] = 1'b1;
    endtask

    // Starts and ends at a negedge with inputs idle; checks ready timing T+1..T+3.
    task automatic do_req(input logic sync, input logic [15:0] addr, input logic [15:0] data,
                          input logic poke, input logic [15:0] poke_addr,
                          input logic [15:0] exp_sdata, input logic [3:0] exp_err);
        valid = 1'b1; msync = sync; maddr = addr; mdata = data;
        @(posedge clk); @(negedge clk);
        check("ready_low_t1", ready, 1'b0);
        if (poke) begin
            valid = 1'b1; msync = 1'b0; maddr = poke_addr; mdata = 16'hDEAD;
        end else begin
            valid = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        valid = 1'b0;
        check("ready_t2", ready, 1'b1);
        check("ssync", ssync, sync);
        check("saddr", saddr, addr);
        check("sdata", sdata, exp_sdata);
        @(posedge clk); @(negedge clk);
        check("ready_low_t3", ready, 1'b0);
        check("err", err, exp_err);
        check("flat", flat, model_flat());
    endtask

    typedef struct {
        logic        sync;
        logic [15:0] addr;
        logic [15:0] data;
        logic        poke;
        logic [15:0] poke_addr;
        logic [15:0] exp_sdata;
        logic [3:0]  exp_err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [15:0] ms;
        int          ready_cnt;

        vecs[0] = '{1'b0, 16'd3,     16'hA5A5, 1'b0, 16'd0, 16'hA5A5, 4'b0000};
        vecs[1] = '{1'b1, 16'd3,     16'h0000, 1'b0, 16'd0, 16'hA5A5, 4'b0000};
        vecs[2] = '{1'b0, 16'd8,     16'h1234, 1'b0, 16'd0, 16'h0000, 4'b0001};
        vecs[3] = '{1'b1, 16'd8,     16'h0000, 1'b0, 16'd0, 16'h0000, 4'b0001};
        vecs[4] = '{1'b0, 16'd7,     16'h0001, 1'b0, 16'd0, 16'h0001, 4'b0001};
        vecs[5] = '{1'b1, 16'd7,     16'h0000, 1'b0, 16'd0, 16'h0001, 4'b0001};
        vecs[6] = '{1'b1, 16'd0,     16'h0000, 1'b0, 16'd0, 16'h0000, 4'b0001};
        vecs[7] = '{1'b0, 16'd1,     16'h1111, 1'b1, 16'd2, 16'h1111, 4'b0011};
        vecs[8] = '{1'b1, 16'd2,     16'h0000, 1'b0, 16'd0, 16'h0000, 4'b0011};
        vecs[9] = '{1'b0, 16'hFFFF,  16'h5A5A, 1'b0, 16'd0, 16'h0000, 4'b0011};

        rst = 1'b1;
        valid = 1'b0; msync = 1'b0; mdata = '0; maddr = '0;
        valid6 = 1'b0; msync6 = 1'b0; mdata6 = '0; maddr6 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_ready", ready, 1'b0);
        check("rst_ssync", ssync, 1'b0);
        check("rst_sdata", sdata, 16'h0);
        check("rst_saddr", saddr, 16'h0);
        check("rst_flat", flat, 128'h0);
        check("rst_err", err, 4'h0);
        check("rst_ready6", ready6, 1'b0);
        check("rst_flat6", flat6, 128'h0);

        // Directed vectors: write/readback, out of range, busy drop, no wrap.
        for (int i = 0; i < 10; i++) begin
            model_req(vecs[i].sync, vecs[i].addr, vecs[i].data, vecs[i].poke, ms);
            do_req(vecs[i].sync, vecs[i].addr, vecs[i].data, vecs[i].poke, vecs[i].poke_addr,
                   vecs[i].exp_sdata, vecs[i].exp_err);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 150; n++) begin
            logic        rs, rp;
            logic [15:0] ra, rd, rpa;
            rs  = 1'($urandom_range(0, 1));
            ra  = 16'($urandom_range(0, 11));
            if ($urandom_range(0, 9) == 0) ra = 16'($urandom);
            rd  = 16'($urandom);
            rp  = ($urandom_range(0, 7) == 0);
            rpa = 16'($urandom_range(0, 7));
            model_req(rs, ra, rd, rp, ms);
            do_req(rs, ra, rd, rp, rpa, ms, {2'b00, m_err});
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset one cycle after capture: response must never appear.
        valid = 1'b1; msync = 1'b0; maddr = 16'd5; mdata = 16'h7777;
        @(posedge clk); @(negedge clk);
        valid = 1'b0;
        rst   = 1'b1;
        ready_cnt = 0;
        if (ready) ready_cnt++;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        if (ready) ready_cnt++;
        check("abort_flat", flat, model_flat());
        check("abort_err", err, 4'h0);
        check("abort_sdata", sdata, 16'h0);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            if (ready) ready_cnt++;
        end
        check("abort_no_ready", ready_cnt, 0);

        // Single-cycle delay instance with base 16'h10.
        valid6 = 1'b1; msync6 = 1'b0; maddr6 = 16'h0010; mdata6 = 16'hBEEF;
        @(posedge clk); @(negedge clk);
        valid6 = 1'b0;
        check("d1_ready_t1", ready6, 1'b1);
        check("d1_sdata", sdata6, 16'hBEEF);
        check("d1_saddr", saddr6, 16'h0010);
        check("d1_flat", flat6, {112'h0, 16'hBEEF});
        @(posedge clk); @(negedge clk);
        check("d1_ready_low", ready6, 1'b0);

        valid6 = 1'b1; msync6 = 1'b0; maddr6 = 16'h000F; mdata6 = 16'h5555;
        @(posedge clk); @(negedge clk);
        valid6 = 1'b0;
        check("d1_wrap_ready", ready6, 1'b1);
        check("d1_wrap_sdata", sdata6, 16'h0);
        check("d1_wrap_err", err6, 4'b0001);
        check("d1_wrap_flat", flat6, {112'h0, 16'hBEEF});
        @(posedge clk); @(negedge clk);

        valid6 = 1'b1; msync6 = 1'b1; maddr6 = 16'h0010; mdata6 = 16'h0;
        @(posedge clk); @(negedge clk);
        valid6 = 1'b0;
        check("d1_read_ready", ready6, 1'b1);
        check("d1_read_ssync", ssync6, 1'b1);
        check("d1_read_sdata", sdata6, 16'hBEEF);
        @(posedge clk); @(negedge clk);

        valid6 = 1'b1; msync6 = 1'b0; maddr6 = 16'h0017; mdata6 = 16'h1357;
        @(posedge clk); @(negedge clk);
        valid6 = 1'b0;
        check("d1_top_sdata", sdata6, 16'h1357);
        check("d1_top_flat", flat6, {16'h1357, 96'h0, 16'hBEEF});
        @(posedge clk); @(negedge clk);

        valid6 = 1'b1; msync6 = 1'b0; maddr6 = 16'h0018; mdata6 = 16'h2468;
        @(posedge clk); @(negedge clk);
        valid6 = 1'b0;
        check("d1_above_sdata", sdata6, 16'h0);
        check("d1_above_flat", flat6, {16'h1357, 96'h0, 16'hBEEF});
        check("d1_above_err", err6, 4'b0001);
        @(posedge clk); @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
